// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default width.
package mdu_pkg;
  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mdu_state_e;
endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-divide step: shift in one dividend bit, trial-subtract the divisor.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_in, bit_in};
  assign trial   = shifted - {1'b0, divisor};
  // shifted < 2*divisor always holds, so the top bit of trial is a clean borrow flag
  assign q_bit   = ~trial[WIDTH];
  assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Define MDU_SIGNED_EN to make MULT/DIV signed; otherwise they behave as MULTU/DIVU.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO handled here
// RUN   | one multiply/divide iteration per cycle, WIDTH cycles
// DONE  | result just written, done pulse; new start accepted
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  mdu_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   rs_q;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH:0]     sum;
  logic               is_div;
  logic               div_zero;
  logic               q_bit;
  logic               launch;

  assign launch = start && !busy && !op[2];

`ifdef MDU_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic signed_op;
  logic sign_a;
  logic sign_b;

  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign sign_a    = signed_op & rs_data[WIDTH-1];
  assign sign_b    = signed_op & rt_data[WIDTH-1];
  assign mag_a     = sign_a ? -rs_data : rs_data;
  assign mag_b     = sign_b ? -rt_data : rt_data;
`else
  assign mag_a = rs_data;
  assign mag_b = rt_data;
`endif

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in (acc[2*WIDTH-1:WIDTH]),
    .bit_in (acc[WIDTH-1]),
    .divisor(opb),
    .rem_out(rem_nx),
    .q_bit  (q_bit)
  );

  // Multiply keeps the multiplier in the low half and shifts right; divide shifts left.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

  always_comb begin
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) acc_next = {rem_nx, acc[WIDTH-2:0], q_bit};
  end

  always_comb begin
    res_hi = acc_next[2*WIDTH-1:WIDTH];
    res_lo = acc_next[WIDTH-1:0];
`ifdef MDU_SIGNED_EN
    if (is_div) begin
      if (neg_q) res_lo = -acc_next[WIDTH-1:0];
      if (neg_r) res_hi = -acc_next[2*WIDTH-1:WIDTH];
    end else if (neg_q) begin
      {res_hi, res_lo} = -acc_next;
    end
`endif
    // Divide by zero reports the raw dividend, not its magnitude
    if (is_div && div_zero) begin
      res_lo = '1;
      res_hi = rs_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      rs_q     <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MDU_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          if (launch) begin
            state    <= RUN;
            busy     <= 1'b1;
            cnt      <= '0;
            acc      <= {{WIDTH{1'b0}}, mag_a};
            opb      <= mag_b;
            is_div   <= op[1];
            div_zero <= (rt_data == '0);
            rs_q     <= rs_data;
`ifdef MDU_SIGNED_EN
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
`endif
          end else if (start && op == MDU_MTHI) begin
            hi <= rs_data;
          end else if (start && op == MDU_MTLO) begin
            lo <= rs_data;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops against an arithmetic model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    logic   s;
    longint x;
    longint y;
    longint p;
    s = 1'b0;
`ifdef MDU_SIGNED_EN
    s = (o == 3'd0) || (o == 3'd2);
`endif
    x = s ? longint'($signed(a)) : longint'({32'b0, a});
    y = s ? longint'($signed(b)) : longint'({32'b0, b});
    if (!o[1]) begin
      p = x * y;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      l = '1;
      h = a;
    end else begin
      l = 32'(x / y);
      h = 32'(x % y);
    end
  endfunction

  // Called at a negedge; leaves the bench at the negedge after the accepting edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7)); rs_data = $urandom; rt_data = $urandom;
    chk("done_low_after_start", done, 1'b0);
  endtask

  task automatic wait_done(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input int inject);
    logic [31:0] eh;
    logic [31:0] el;
    int k;
    int bcnt;
    logic stable;
    model(o, a, b, eh, el);
    k = 1;
    bcnt = busy ? 1 : 0;
    stable = 1'b1;
    while (!done && k < 60) begin
      if (hi !== m_hi || lo !== m_lo) stable = 1'b0;
      if (k == inject) begin
        start = 1'b1; op = MDU_DIVU; rs_data = 32'd9; rt_data = 32'd3;
      end
      @(negedge clk);
      start = 1'b0;
      k++;
      if (busy) bcnt++;
    end
    chk({tag, "_latency"}, k, 33);
    chk({tag, "_busy_cycles"}, bcnt, 32);
    chk({tag, "_hilo_stable"}, stable, 1'b1);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo_const", lo, 32'h0000_0001);

    // back-to-back: next op accepted in the DONE cycle
    launch(MDU_DIVU, 32'd100, 32'd7);
    chk("b2b_busy", busy, 1'b1);
    wait_done("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 0);
    chk("divu_100_7_lo_const", lo, 32'd14);
    chk("divu_100_7_hi_const", hi, 32'd2);

    launch(MDU_DIVU, 32'h1234, 32'h0);
    wait_done("divu_zero", MDU_DIVU, 32'h1234, 32'h0, 0);
    chk("divu_zero_lo_const", lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi_const", hi, 32'h1234);

    launch(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_m3_5", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 0);
    launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    launch(MDU_DIV, 32'hFFFF_FF00, 32'h0);
    wait_done("div_zero_neg", MDU_DIV, 32'hFFFF_FF00, 32'h0, 0);

    @(negedge clk);
    launch(MDU_MTHI, 32'hA5A5_A5A5, 32'h0);
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_lo_kept", lo, m_lo);
    chk("mthi_no_busy", busy, 1'b0);
    m_hi = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("mthi_no_done", done, 1'b0);

    launch(MDU_MTLO, 32'h5A5A_0F0F, 32'h0);
    chk("mtlo_lo", lo, 32'h5A5A_0F0F);
    chk("mtlo_hi_kept", hi, m_hi);
    m_lo = 32'h5A5A_0F0F;

    launch(3'd6, 32'hDEAD_BEEF, 32'h1);
    chk("rsvd_hi", hi, m_hi);
    chk("rsvd_lo", lo, m_lo);
    chk("rsvd_busy", busy, 1'b0);
    launch(3'd7, 32'hDEAD_BEEF, 32'h1);
    chk("rsvd7_busy", busy, 1'b0);
    chk("rsvd7_lo", lo, m_lo);

    launch(MDU_MULTU, 32'd2, 32'd3);
    wait_done("multu_2_3_inject", MDU_MULTU, 32'd2, 32'd3, 5);
    chk("inject_hi_const", hi, 32'd0);
    chk("inject_lo_const", lo, 32'd6);
    @(negedge clk);
    chk("inject_no_restart", busy, 1'b0);
    chk("done_single_pulse", done, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      if (i % 5 == 0) rb = 32'h0;
      else if ($urandom_range(0, 1) == 1) rb = $urandom;
      else rb = $urandom_range(1, 300);
      launch(ro, ra, rb);
      wait_done($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, (i % 3 == 0) ? 7 : 0);
    end

    @(negedge clk);
    launch(MDU_DIVU, 32'hFFFF_0000, 32'd3);
    repeat (9) @(negedge clk);
    chk("midop_busy_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midop_reset_busy", busy, 1'b0);
    chk("midop_reset_done", done, 1'b0);
    chk("midop_reset_hi", hi, 32'h0);
    chk("midop_reset_lo", lo, 32'h0);
    m_hi = 0;
    m_lo = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_idle", busy, 1'b0);
    launch(MDU_MULTU, 32'd4, 32'd4);
    wait_done("multu_4_4", MDU_MULTU, 32'd4, 32'd4, 0);
    chk("multu_4_4_lo_const", lo, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
